adder_share_arbiter: RTL and testbench

//  Round-robin arbiter and 1-stage scheduler that shares a single Adder instance among NUM_REQ requesters
//  (e.g. PC+4 fetch increment, branch-target add, AUIPC). Adder's sel=1 computes in1+4; sel=0 computes in1+in2.

---
 rtl/adder_share_arbiter_pkg.sv | 12 +
 rtl/adder_share_arbiter_adder.sv | 29 ++
 rtl/adder_share_arbiter.sv | 135 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
// Optional feature macro: ADDER_ARB_CARRY_EN (see adder_share_arbiter.sv).
package adder_share_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FULL = 1'b1
   } state_e;

   localparam logic [31:0] ADD_INC = 32'd4;

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// Shared adder: sel=1 -> in1+4, sel=0 -> in1+in2.
// ADDER_ARB_CARRY_EN widens out by one bit to carry the carry-out.
module adder_share_arbiter_adder
   import adder_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sel,
`ifdef ADDER_ARB_CARRY_EN
   output logic [WIDTH:0]   out
`else
   output logic [WIDTH-1:0] out
`endif
);

   logic [WIDTH-1:0] op_b;

   always_comb begin
      op_b = sel ? WIDTH'(ADD_INC) : in2;
`ifdef ADDER_ARB_CARRY_EN
      out = {1'b0, in1} + {1'b0, op_b};
`else
      out = in1 + op_b;
`endif
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, one registered result stage.
// ADDER_ARB_CARRY_EN adds the resp_carry output (registered carry-out of the add).
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ID_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_in1,
   input  logic [NUM_REQ*WIDTH-1:0] req_in2,
   input  logic [NUM_REQ-1:0]       req_sel,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [WIDTH-1:0]         resp_data,
`ifdef ADDER_ARB_CARRY_EN
   output logic                     resp_carry,
`endif
   output logic [ID_W-1:0]          resp_id
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [ID_W-1:0]   win_id;
   logic [NUM_REQ-1:0] grant;
   logic              found, can_accept, accept;
   logic [WIDTH-1:0]  mux_in1, mux_in2;
   logic              mux_sel;
   int unsigned       idx;
`ifdef ADDER_ARB_CARRY_EN
   logic              carry_q, carry_d;
   logic [WIDTH:0]    sum;
`else
   logic [WIDTH-1:0]  sum;
`endif

   // Search offsets 0..NUM_REQ-1 from rr_ptr; first valid requester wins.
   always_comb begin
      grant  = '0;
      found  = 1'b0;
      win_id = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && (j == idx) && req_valid[j]) begin
               found    = 1'b1;
               grant[j] = 1'b1;
               win_id   = ID_W'(j);
            end
         end
      end
      can_accept = (state_q == ST_IDLE) || resp_ready;
      accept     = found && can_accept && !rst;
      req_ready  = accept ? grant : '0;
   end

   always_comb begin
      mux_in1 = req_in1[WIDTH-1:0];
      mux_in2 = req_in2[WIDTH-1:0];
      mux_sel = req_sel[0];
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (grant[j]) begin
            mux_in1 = req_in1[j*WIDTH +: WIDTH];
            mux_in2 = req_in2[j*WIDTH +: WIDTH];
            mux_sel = req_sel[j];
         end
      end
   end

   adder_share_arbiter_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .in1 (mux_in1),
      .in2 (mux_in2),
      .sel (mux_sel),
      .out (sum)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
      id_d     = id_q;
`ifdef ADDER_ARB_CARRY_EN
      carry_d  = carry_q;
`endif
      if (accept) begin
         state_d  = ST_FULL;
         data_d   = sum[WIDTH-1:0];
         id_d     = win_id;
         rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
`ifdef ADDER_ARB_CARRY_EN
         carry_d  = sum[WIDTH];
`endif
      end else if ((state_q == ST_FULL) && resp_ready) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         data_q   <= '0;
         id_q     <= '0;
`ifdef ADDER_ARB_CARRY_EN
         carry_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         id_q     <= id_d;
`ifdef ADDER_ARB_CARRY_EN
         carry_q  <= carry_d;
`endif
      end
   end

   assign resp_valid = (state_q == ST_FULL);
   assign resp_data  = data_q;
   assign resp_id    = id_q;
`ifdef ADDER_ARB_CARRY_EN
   assign resp_carry = carry_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed vector table, reset sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_adder_share_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 32;

   logic            clk;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [NREQ*W-1:0] req_in1;
   logic [NREQ*W-1:0] req_in2;
   logic [NREQ-1:0] req_sel;
   logic            resp_valid;
   logic            resp_ready;
   logic [W-1:0]    resp_data;
   logic [0:0]      resp_id;
`ifdef ADDER_ARB_CARRY_EN
   logic            resp_carry;
`endif

   adder_share_arbiter #(
      .NUM_REQ (NREQ),
      .WIDTH   (W),
      .ID_W    (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .req_sel    (req_sel),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
`ifdef ADDER_ARB_CARRY_EN
      .resp_carry (resp_carry),
`endif
      .resp_id    (resp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [1:0]  s;
      logic [31:0] a0, b0, a1, b1;
      logic        rr;
      logic [1:0]  er;
      logic        ev;
      logic [31:0] ed;
      logic        eid;
   } vec_t;

   function automatic vec_t mk(logic [1:0] v, logic [1:0] s, logic [31:0] a0, logic [31:0] b0,
                               logic [31:0] a1, logic [31:0] b1, logic rr, logic [1:0] er,
                               logic ev, logic [31:0] ed, logic eid);
      vec_t r;
      r.v = v; r.s = s; r.a0 = a0; r.b0 = b0; r.a1 = a1; r.b1 = b1; r.rr = rr;
      r.er = er; r.ev = ev; r.ed = ed; r.eid = eid;
      return r;
   endfunction

   vec_t tbl[15];

   // Reference model state (transaction level)
   logic        m_valid;
   logic [31:0] m_data;
   int          m_id;
   int          m_rr;
   logic        pv[NREQ];
   logic [31:0] pa[NREQ], pb[NREQ];
   logic        ps[NREQ];

   initial begin
      int g;
      logic [1:0] exp_ready;

      // Each row: drive inputs, then expect req_ready for this cycle and the registered outputs
      // resulting from the previous edge.
      tbl[0]  = mk(2'b01, 2'b01, 32'd10,  0, 0,     0,           1'b1, 2'b01, 1'b0, 0,       1'b0);
      tbl[1]  = mk(2'b10, 2'b00, 0,       0, 32'd20, 32'd30,     1'b1, 2'b10, 1'b1, 32'd14,  1'b0);
      tbl[2]  = mk(2'b00, 2'b00, 0,       0, 0,     0,           1'b0, 2'b00, 1'b1, 32'd50,  1'b1);
      tbl[3]  = mk(2'b11, 2'b01, 32'd100, 0, 32'd20, 32'd30,     1'b0, 2'b00, 1'b1, 32'd50,  1'b1);
      tbl[4]  = mk(2'b11, 2'b01, 32'd100, 0, 32'd20, 32'd30,     1'b1, 2'b01, 1'b1, 32'd50,  1'b1);
      tbl[5]  = mk(2'b11, 2'b01, 32'd100, 0, 32'd20, 32'd30,     1'b1, 2'b10, 1'b1, 32'd104, 1'b0);
      tbl[6]  = mk(2'b11, 2'b01, 32'd100, 0, 32'd20, 32'd30,     1'b1, 2'b01, 1'b1, 32'd50,  1'b1);
      tbl[7]  = mk(2'b11, 2'b01, 32'd100, 0, 32'd20, 32'd30,     1'b1, 2'b10, 1'b1, 32'd104, 1'b0);
      tbl[8]  = mk(2'b00, 2'b00, 0,       0, 0,     0,           1'b1, 2'b00, 1'b1, 32'd50,  1'b1);
      tbl[9]  = mk(2'b01, 2'b01, 32'hFFFF_FFFC, 0, 0, 0,         1'b1, 2'b01, 1'b0, 0,       1'b0);
      tbl[10] = mk(2'b00, 2'b00, 0,       0, 0,     0,           1'b0, 2'b00, 1'b1, 32'd0,   1'b0);
      tbl[11] = mk(2'b10, 2'b00, 0,       0, 32'd5, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b1, 32'd0, 1'b0);
      tbl[12] = mk(2'b10, 2'b00, 0,       0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2'b10, 1'b1, 32'd0, 1'b0);
      tbl[13] = mk(2'b00, 2'b00, 0,       0, 0,     0,           1'b1, 2'b00, 1'b1, 32'd4,   1'b1);
      tbl[14] = mk(2'b00, 2'b00, 0,       0, 0,     0,           1'b1, 2'b00, 1'b0, 0,       1'b0);

      // Reset state with requests pending
      rst = 1'b1; req_valid = 2'b11; req_sel = '0; req_in1 = '0; req_in2 = '0; resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(req_ready), 64'(2'b00));
      chk("reset_valid", 64'(resp_valid), 64'(1'b0));
      chk("reset_data",  64'(resp_data), 64'(0));
      chk("reset_id",    64'(resp_id), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         req_valid  = tbl[i].v;
         req_sel    = tbl[i].s;
         req_in1    = {tbl[i].a1, tbl[i].a0};
         req_in2    = {tbl[i].b1, tbl[i].b0};
         resp_ready = tbl[i].rr;
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].er));
         chk($sformatf("vec%0d_valid", i), 64'(resp_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_data", i), 64'(resp_data), 64'(tbl[i].ed));
            chk($sformatf("vec%0d_id", i), 64'(resp_id), 64'(tbl[i].eid));
         end
`ifdef ADDER_ARB_CARRY_EN
         if (i == 10) chk("wrap_carry", 64'(resp_carry), 64'(1'b1));
`endif
         @(posedge clk);
         #1;
      end

      // Reset while a result is held: everything clears immediately, rr_ptr returns to 0
      req_valid = 2'b01; req_sel = 2'b01; req_in1 = {32'd0, 32'd7}; resp_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("midop_valid", 64'(resp_valid), 64'(1'b1));
      chk("midop_data",  64'(resp_data), 64'(32'd11));
      rst = 1'b1;
      #1;
      chk("async_valid", 64'(resp_valid), 64'(1'b0));
      chk("async_data",  64'(resp_data), 64'(0));
      chk("async_ready", 64'(req_ready), 64'(2'b00));
      @(posedge clk);
      #1;
      rst = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
      #1;
      chk("post_rst_grant", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      #1;
      chk("post_rst_data", 64'(resp_data), 64'(32'd11));
      chk("post_rst_id",   64'(resp_id), 64'(0));

      // Randomized traffic against the reference model
      rst = 1'b1; req_valid = '0;
      #1;
      rst = 1'b0;
      m_valid = 1'b0; m_data = '0; m_id = 0; m_rr = 0;
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 2) != 0) begin
               pv[i] = 1'b1;
               pa[i] = $urandom;
               if ($urandom_range(0, 15) == 0) pa[i] = 32'hFFFF_FFFC;
               pb[i] = $urandom;
               ps[i] = 1'($urandom_range(0, 1));
            end
            req_valid[i]        = pv[i];
            req_sel[i]          = ps[i];
            req_in1[i*W +: W]   = pa[i];
            req_in2[i*W +: W]   = pb[i];
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = -1;
         if (!m_valid || resp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (m_rr + k) % NREQ;
               if (g < 0 && pv[j]) g = j;
            end
         end
         exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
         chk("rand_ready", 64'(req_ready), 64'(exp_ready));
         chk("rand_valid", 64'(resp_valid), 64'(m_valid));
         if (m_valid) begin
            chk("rand_data", 64'(resp_data), 64'(m_data));
            chk("rand_id",   64'(resp_id), 64'(m_id));
         end
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = pa[g] + (ps[g] ? 32'd4 : pb[g]);
            m_id    = g;
            m_rr    = (g + 1) % NREQ;
            pv[g]   = 1'b0;
         end else if (resp_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
